truth_table_scanner: RTL and testbench



---
 rtl/tt_scan_pkg.sv | 18 +
 rtl/truth_table_scanner_if.sv | 31 +++
 rtl/settle_timer.sv | 32 +++
 rtl/truth_table_scanner.sv | 141 ++++++++++++++
 tb/tb_truth_table_scanner.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/tt_scan_pkg.sv
// rtl/tt_scan_pkg.sv - shared types and width helpers for the truth-table scanner
package tt_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int N_IN_DEF = 5;
    localparam int TT_W     = 1 << N_IN_DEF;

    function automatic int tt_width(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// rtl/truth_table_scanner_if.sv - control, golden table and result bundle of the scanner
interface truth_table_scanner_if
    import tt_scan_pkg::*;
#(
    parameter int N_IN = 5
);
    localparam int W = tt_width(N_IN);

    logic            start;
    logic            abort;
    logic [W-1:0]    expected;
    logic            f_in;
    logic [N_IN-1:0] vec_out;
    logic            busy;
    logic            done;
    logic [W-1:0]    table_out;
    logic            pass;
    logic [N_IN:0]   mismatch_count;
    logic [N_IN-1:0] first_fail;

    modport master (
        output start, abort, expected, f_in,
        input  vec_out, busy, done, table_out, pass, mismatch_count, first_fail
    );

    modport slave (
        input  start, abort, expected, f_in,
        output vec_out, busy, done, table_out, pass, mismatch_count, first_fail
    );

endinterface

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - 4-bit loadable down-counter timing the per-vector settle window
module settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       expire
);
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expire on the last settle cycle so SAMPLE follows exactly load_val cycles after load.
    assign expire = (cnt_q == 4'd1);

endmodule

// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - walks all input vectors of a boolean block and checks its truth table
module truth_table_scanner
    import tt_scan_pkg::*;
#(
    parameter int N_IN       = 5,
    parameter int SETTLE_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    truth_table_scanner_if.slave bus
);
    localparam int              W          = tt_width(N_IN);
    localparam logic [3:0]      SETTLE_LD  = 4'(SETTLE_CYC);
    localparam logic            HAS_SETTLE = (SETTLE_CYC != 0);
    localparam state_e          VEC_ENTRY  = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
    localparam logic [N_IN-1:0] LAST_VEC   = '1;
    localparam logic [N_IN-1:0] VEC_ONE    = 1;
    localparam logic [N_IN:0]   CNT_ONE    = 1;

    state_e          state_q, state_d;
    logic [W-1:0]    exp_q, exp_d;
    logic [W-1:0]    table_q, table_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [N_IN:0]   cnt_q, cnt_d;
    logic [N_IN-1:0] ff_q, ff_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            tmr_load, tmr_en, tmr_expire;

    settle_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (SETTLE_LD),
        .en       (tmr_en),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        table_d  = table_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        ff_d     = ff_q;
        busy_d   = busy_q;
        pass_d   = pass_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        // busy_q is high exactly in SETTLE/SAMPLE, the only states where abort matters.
        if (busy_q && bus.abort) begin
            state_d = IDLE;
            vec_d   = '0;
            busy_d  = 1'b0;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        exp_d    = bus.expected;
                        table_d  = '0;
                        vec_d    = '0;
                        cnt_d    = '0;
                        ff_d     = '0;
                        pass_d   = 1'b0;
                        busy_d   = 1'b1;
                        state_d  = VEC_ENTRY;
                        tmr_load = HAS_SETTLE;
                    end
                end
                SETTLE: begin
                    tmr_en = 1'b1;
                    if (tmr_expire) begin
                        state_d = SAMPLE;
                    end
                end
                SAMPLE: begin
                    table_d[vec_q] = bus.f_in;
                    if (bus.f_in != exp_q[vec_q]) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q == '0) begin
                            ff_d = vec_q;
                        end
                    end
                    if (vec_q == LAST_VEC) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (cnt_d == '0);
                        vec_d   = '0;
                    end else begin
                        vec_d    = vec_q + VEC_ONE;
                        state_d  = VEC_ENTRY;
                        tmr_load = HAS_SETTLE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            exp_q   <= '0;
            table_q <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
            ff_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            table_q <= table_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            ff_q    <= ff_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.vec_out        = vec_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.table_out      = table_q;
    assign bus.pass           = pass_q;
    assign bus.mismatch_count = cnt_q;
    assign bus.first_fail     = ff_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - scoreboard bench for the truth-table scanner
module tb_truth_table_scanner;

    typedef struct {
        logic [31:0] tbl;
        logic        pass;
        logic [5:0]  cnt;
        logic [4:0]  ff;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic f_mode = 1'b0;
    int   edge_cnt = 0;
    int   start_edge0 = 0;
    int   start_edge1 = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    localparam logic [31:0] PARITY_TT = 32'h9669_6996;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    truth_table_scanner_if #(.N_IN(5)) b0 ();
    truth_table_scanner_if #(.N_IN(5)) b1 ();

    assign b0.f_in = f_mode ? 1'b1 : ^b0.vec_out;
    assign b1.f_in = ^b1.vec_out;

    truth_table_scanner #(.N_IN(5), .SETTLE_CYC(1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    truth_table_scanner #(.N_IN(5), .SETTLE_CYC(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic score(input string who, input exp_t e, input logic [31:0] tbl, input logic pass,
                         input logic [5:0] cnt, input logic [4:0] ff, input int cyc,
                         input logic [4:0] vec, input logic busy);
        chk({who, " table_out"}, 64'(tbl), 64'(e.tbl));
        chk({who, " pass"}, 64'(pass), 64'(e.pass));
        chk({who, " mismatch_count"}, 64'(cnt), 64'(e.cnt));
        chk({who, " first_fail"}, 64'(ff), 64'(e.ff));
        chk({who, " done cycle"}, 64'(cyc), 64'(e.cyc));
        chk({who, " vec_out at done"}, 64'(vec), 64'd0);
        chk({who, " busy at done"}, 64'(busy), 64'd0);
    endtask

    always @(negedge clk) begin
        if (b0.done) begin
            if (q0.size() == 0) begin
                chk("dut0 unexpected done", 64'd1, 64'd0);
            end else begin
                score("dut0", q0.pop_front(), b0.table_out, b0.pass, b0.mismatch_count,
                      b0.first_fail, edge_cnt - start_edge0 + 1, b0.vec_out, b0.busy);
            end
        end
    end

    always @(negedge clk) begin
        if (b1.done) begin
            if (q1.size() == 0) begin
                chk("dut1 unexpected done", 64'd1, 64'd0);
            end else begin
                score("dut1", q1.pop_front(), b1.table_out, b1.pass, b1.mismatch_count,
                      b1.first_fail, edge_cnt - start_edge1 + 1, b1.vec_out, b1.busy);
            end
        end
    end

    task automatic start0(input logic [31:0] ex, input bit push, input exp_t e);
        @(negedge clk);
        b0.expected = ex;
        b0.start    = 1'b1;
        if (push) q0.push_back(e);
        @(posedge clk);
        #1;
        start_edge0 = edge_cnt;
        @(negedge clk);
        b0.start = 1'b0;
    endtask

    task automatic wait_cycle0(input int k);
        while (edge_cnt - start_edge0 + 1 < k) @(negedge clk);
    endtask

    task automatic chk_zero(input string who, input logic [4:0] vec, input logic busy, input logic done,
                            input logic [31:0] tbl, input logic pass, input logic [5:0] cnt,
                            input logic [4:0] ff);
        chk({who, " vec_out"}, 64'(vec), 64'd0);
        chk({who, " busy"}, 64'(busy), 64'd0);
        chk({who, " done"}, 64'(done), 64'd0);
        chk({who, " table_out"}, 64'(tbl), 64'd0);
        chk({who, " pass"}, 64'(pass), 64'd0);
        chk({who, " mismatch_count"}, 64'(cnt), 64'd0);
        chk({who, " first_fail"}, 64'(ff), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        b0.start = 1'b0; b0.abort = 1'b0; b0.expected = '0;
        b1.start = 1'b0; b1.abort = 1'b0; b1.expected = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("reset dut0", b0.vec_out, b0.busy, b0.done, b0.table_out, b0.pass, b0.mismatch_count, b0.first_fail);
        chk_zero("reset dut1", b1.vec_out, b1.busy, b1.done, b1.table_out, b1.pass, b1.mismatch_count, b1.first_fail);
        rst = 1'b0;

        // Parity function against its correct table.
        start0(PARITY_TT, 1'b1, '{PARITY_TT, 1'b1, 6'd0, 5'd0, 65});
        chk("busy after start", 64'(b0.busy), 64'd1);
        repeat (70) @(negedge clk);
        chk("parity run done seen", 64'(q0.size()), 64'd0);

        // Golden table with bits 5 and 20 flipped.
        start0(PARITY_TT ^ 32'h0010_0020, 1'b1, '{PARITY_TT, 1'b0, 6'd2, 5'd5, 65});
        repeat (70) @(negedge clk);
        chk("flipped run done seen", 64'(q0.size()), 64'd0);

        // Constant-1 function against an all-zero table: every vector mismatches.
        f_mode = 1'b1;
        start0(32'h0, 1'b1, '{32'hFFFF_FFFF, 1'b0, 6'd32, 5'd0, 65});
        repeat (70) @(negedge clk);
        chk("all-fail run done seen", 64'(q0.size()), 64'd0);
        f_mode = 1'b0;

        // Abort during cycle 10 (SAMPLE of vector 4): vectors 0..3 already captured.
        start0(PARITY_TT, 1'b0, '{PARITY_TT, 1'b1, 6'd0, 5'd0, 65});
        wait_cycle0(10);
        b0.abort = 1'b1;
        @(posedge clk);
        #1;
        chk("abort busy", 64'(b0.busy), 64'd0);
        chk("abort vec_out", 64'(b0.vec_out), 64'd0);
        chk("abort pass", 64'(b0.pass), 64'd0);
        chk("abort partial table", 64'(b0.table_out), 64'h6);
        @(negedge clk);
        b0.abort = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort busy stays low", 64'(b0.busy), 64'd0);
        start0(PARITY_TT, 1'b1, '{PARITY_TT, 1'b1, 6'd0, 5'd0, 65});
        repeat (70) @(negedge clk);
        chk("post-abort run done seen", 64'(q0.size()), 64'd0);

        // Reset pulse in cycle 20, vectors 0..8 captured beforehand.
        start0(PARITY_TT, 1'b0, '{PARITY_TT, 1'b1, 6'd0, 5'd0, 65});
        wait_cycle0(20);
        chk("pre-reset partial table", 64'(b0.table_out), 64'h196);
        rst = 1'b1;
        #1;
        chk_zero("mid-scan reset", b0.vec_out, b0.busy, b0.done, b0.table_out, b0.pass, b0.mismatch_count, b0.first_fail);
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        chk("post-reset busy", 64'(b0.busy), 64'd0);

        // Zero-settle instance: start during busy is ignored, expected latched at start.
        @(negedge clk);
        b1.expected = PARITY_TT;
        b1.start    = 1'b1;
        q1.push_back('{PARITY_TT, 1'b1, 6'd0, 5'd0, 33});
        @(posedge clk);
        #1;
        start_edge1 = edge_cnt;
        @(negedge clk);
        b1.start = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            chk($sformatf("dut1 busy cycle %0d", k), 64'(b1.busy), 64'((k <= 32) ? 1 : 0));
            if (k == 5) begin
                b1.start    = 1'b1;
                b1.expected = 32'h0;
            end
            if (k == 6) begin
                b1.start = 1'b0;
            end
            @(negedge clk);
        end
        chk("dut1 run done seen", 64'(q1.size()), 64'd0);

        // start and abort together in IDLE are ignored.
        b1.expected = PARITY_TT;
        b1.start    = 1'b1;
        b1.abort    = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        b1.abort = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("dut1 start+abort busy", 64'(b1.busy), 64'd0);
            @(negedge clk);
        end
        repeat (40) @(negedge clk);

        chk("dut0 scoreboard empty", 64'(q0.size()), 64'd0);
        chk("dut1 scoreboard empty", 64'(q1.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
